// File: rtl/qsip_axil_slave_regs.sv
// qsip_axil_slave_regs
//   AXI4-Lite responder holding NUM_REGS 32-bit read/write registers. It sits
//   between the AXI interconnect and the qsip core, and REG_OUT drives the
//   core control inputs straight from the register flops.
//
// Ports
//   ACLK, ARESET          clock (rising edge), synchronous active-high reset
//   AW*/W*/B*             write address, write data and write response channels
//   AR*/R*                read address and read data channels
//   AWPROT, ARPROT        accepted and ignored
//   REG_OUT               register contents, reg i at bits [32*i+31:32*i]
//
// Word index = ADDR[AW-1:2]; ADDR[1:0] is ignored. Out-of-range indexes
// answer SLVERR; their reads return 0.
//
// Build option QSIP_AXIL_WRCOUNT_EN: adds a read-only 32-bit counter of OKAY
// write commits at index NUM_REGS. Writes to that index return SLVERR and leave
// the counter unchanged.
module qsip_axil_slave_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int NUM_REGS           = 4
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   AWADDR,
    input  logic [2:0]                      AWPROT,
    input  logic                            AWVALID,
    output logic                            AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] WSTRB,
    input  logic                            WVALID,
    output logic                            WREADY,
    output logic [1:0]                      BRESP,
    output logic                            BVALID,
    input  logic                            BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   ARADDR,
    input  logic [2:0]                      ARPROT,
    input  logic                            ARVALID,
    output logic                            ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]                      RRESP,
    output logic                            RVALID,
    input  logic                            RREADY,
    output logic [32*NUM_REGS-1:0]          REG_OUT
);
    localparam int         DW          = C_S_AXI_DATA_WIDTH;
    localparam int         IDX_W       = C_S_AXI_ADDR_WIDTH - 2;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {WR_IDLE, WR_COLLECT, WR_RESP} wr_state_t;
    typedef enum logic       {RD_IDLE, RD_RESP} rd_state_t;

    wr_state_t           wr_state_q, wr_state_d;
    logic                aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic [IDX_W-1:0]    awidx_q, awidx_d;
    logic [DW-1:0]       wdata_q, wdata_d;
    logic [DW/8-1:0]     wstrb_q, wstrb_d;
    logic                awready_q, awready_d, wready_q, wready_d;
    logic [1:0]          bresp_q, bresp_d;
    logic [DW-1:0]       regs_q [NUM_REGS];
    logic [DW-1:0]       regs_d [NUM_REGS];

    rd_state_t           rd_state_q, rd_state_d;
    logic                arready_q, arready_d;
    logic [DW-1:0]       rdata_q, rdata_d;
    logic [1:0]          rresp_q, rresp_d;

`ifdef QSIP_AXIL_WRCOUNT_EN
    logic [DW-1:0]       wrcount_q, wrcount_d;
`endif

    logic                aw_hs, w_hs, have_aw, have_w, wr_commit, wr_ok, ar_hs;
    logic [IDX_W-1:0]    wr_idx, rd_idx;
    logic [DW-1:0]       wr_data;
    logic [DW/8-1:0]     wr_strb;

    logic unused_ok;
    assign unused_ok = ^{AWPROT, ARPROT, AWADDR[1:0], ARADDR[1:0]};

    // Write channel: AW and W are latched independently; the commit happens at
    // the edge where both are available, using the live bus value for whichever
    // half handshakes at that same edge.
    always_comb begin
        wr_state_d = wr_state_q;
        aw_held_d  = aw_held_q;
        w_held_d   = w_held_q;
        awidx_d    = awidx_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bresp_d    = bresp_q;
        wr_commit  = 1'b0;

        aw_hs   = AWVALID && awready_q;
        w_hs    = WVALID && wready_q;
        have_aw = aw_held_q || aw_hs;
        have_w  = w_held_q || w_hs;
        wr_idx  = aw_hs ? AWADDR[C_S_AXI_ADDR_WIDTH-1:2] : awidx_q;
        wr_data = w_hs ? WDATA : wdata_q;
        wr_strb = w_hs ? WSTRB : wstrb_q;
        wr_ok   = (32'(wr_idx) < 32'(NUM_REGS));

        case (wr_state_q)
            WR_IDLE, WR_COLLECT: begin
                if (aw_hs) begin
                    aw_held_d = 1'b1;
                    awidx_d   = AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
                end
                if (w_hs) begin
                    w_held_d = 1'b1;
                    wdata_d  = WDATA;
                    wstrb_d  = WSTRB;
                end
                if (have_aw && have_w) begin
                    wr_commit  = 1'b1;
                    aw_held_d  = 1'b0;
                    w_held_d   = 1'b0;
                    bresp_d    = wr_ok ? RESP_OKAY : RESP_SLVERR;
                    wr_state_d = WR_RESP;
                end else if (have_aw || have_w) begin
                    wr_state_d = WR_COLLECT;
                end
            end
            WR_RESP: begin
                if (BREADY) begin
                    wr_state_d = WR_IDLE;
                end
            end
            default: wr_state_d = WR_IDLE;
        endcase

        // A held half, or an outstanding response, blocks further acceptance.
        awready_d = !aw_held_d && (wr_state_d != WR_RESP);
        wready_d  = !w_held_d && (wr_state_d != WR_RESP);
    end

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (wr_commit && wr_ok) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (32'(wr_idx) == 32'(i)) begin
                    for (int k = 0; k < DW/8; k++) begin
                        if (wr_strb[k]) begin
                            regs_d[i][8*k +: 8] = wr_data[8*k +: 8];
                        end
                    end
                end
            end
        end
    end

`ifdef QSIP_AXIL_WRCOUNT_EN
    always_comb begin
        wrcount_d = wrcount_q;
        if (wr_commit && wr_ok) begin
            wrcount_d = wrcount_q + 1'b1;
        end
    end
`endif

    // Read channel: data is captured from the current register flops, so a
    // write committing at the same edge is not yet visible.
    always_comb begin
        rd_state_d = rd_state_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        ar_hs      = ARVALID && arready_q;
        rd_idx     = ARADDR[C_S_AXI_ADDR_WIDTH-1:2];

        case (rd_state_q)
            RD_IDLE: begin
                if (ar_hs) begin
                    rd_state_d = RD_RESP;
                    rdata_d    = '0;
                    rresp_d    = RESP_SLVERR;
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (32'(rd_idx) == 32'(i)) begin
                            rdata_d = regs_q[i];
                            rresp_d = RESP_OKAY;
                        end
                    end
`ifdef QSIP_AXIL_WRCOUNT_EN
                    if (32'(rd_idx) == 32'(NUM_REGS)) begin
                        rdata_d = wrcount_q;
                        rresp_d = RESP_OKAY;
                    end
`endif
                end
            end
            RD_RESP: begin
                if (RREADY) begin
                    rd_state_d = RD_IDLE;
                end
            end
            default: rd_state_d = RD_IDLE;
        endcase

        arready_d = (rd_state_d != RD_RESP);
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wr_state_q <= WR_IDLE;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            awidx_q    <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            rd_state_q <= RD_IDLE;
            arready_q  <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
`ifdef QSIP_AXIL_WRCOUNT_EN
            wrcount_q  <= '0;
`endif
        end else begin
            wr_state_q <= wr_state_d;
            aw_held_q  <= aw_held_d;
            w_held_q   <= w_held_d;
            awidx_q    <= awidx_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bresp_q    <= bresp_d;
            rd_state_q <= rd_state_d;
            arready_q  <= arready_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
`ifdef QSIP_AXIL_WRCOUNT_EN
            wrcount_q  <= wrcount_d;
`endif
        end
    end

    assign AWREADY = awready_q;
    assign WREADY  = wready_q;
    assign BVALID  = (wr_state_q == WR_RESP);
    assign BRESP   = bresp_q;
    assign ARREADY = arready_q;
    assign RVALID  = (rd_state_q == RD_RESP);
    assign RDATA   = rdata_q;
    assign RRESP   = rresp_q;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
        assign REG_OUT[32*g +: 32] = regs_q[g];
    end

endmodule

// File: tb/tb_qsip_axil_slave_regs.sv
// Testbench for qsip_axil_slave_regs. Address width 5 so that 0x10 and above
// decode as out-of-range (or as the write counter when QSIP_AXIL_WRCOUNT_EN).
module tb_qsip_axil_slave_regs;
    localparam int AW   = 5;
    localparam int NREG = 4;

    logic              ACLK = 1'b0;
    logic              ARESET;
    logic [AW-1:0]     AWADDR;
    logic [2:0]        AWPROT;
    logic              AWVALID;
    logic              AWREADY;
    logic [31:0]       WDATA;
    logic [3:0]        WSTRB;
    logic              WVALID;
    logic              WREADY;
    logic [1:0]        BRESP;
    logic              BVALID;
    logic              BREADY;
    logic [AW-1:0]     ARADDR;
    logic [2:0]        ARPROT;
    logic              ARVALID;
    logic              ARREADY;
    logic [31:0]       RDATA;
    logic [1:0]        RRESP;
    logic              RVALID;
    logic              RREADY;
    logic [32*NREG-1:0] REG_OUT;

    always #5 ACLK = ~ACLK;

    qsip_axil_slave_regs #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(AW),
        .NUM_REGS(NREG)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .REG_OUT(REG_OUT)
    );

    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [31:0] model_regs [NREG];
    logic [31:0] wr_count;
    logic [1:0]  bq [$];
    logic [33:0] rq [$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        tests_run++;
        tests_failed++;
        $display("FAIL %s: got no event, want one within the cycle bound", name);
    endtask

    // Reference model: word-addressed register array with byte enables.
    function automatic logic [1:0] model_write(input logic [AW-1:0] addr, input logic [31:0] data,
                                               input logic [3:0] strb);
        int idx;
        idx = int'(addr) / 4;
        if (idx >= NREG) return 2'b10;
        for (int k = 0; k < 4; k++) begin
            if (strb[k]) model_regs[idx][8*k +: 8] = data[8*k +: 8];
        end
        wr_count = wr_count + 32'd1;
        return 2'b00;
    endfunction

    function automatic logic [33:0] model_read(input logic [AW-1:0] addr);
        int idx;
        idx = int'(addr) / 4;
        if (idx < NREG) return {2'b00, model_regs[idx]};
`ifdef QSIP_AXIL_WRCOUNT_EN
        if (idx == NREG) return {2'b00, wr_count};
`endif
        return {2'b10, 32'h0};
    endfunction

    function automatic logic [32*NREG-1:0] model_flat();
        logic [32*NREG-1:0] f;
        for (int i = 0; i < NREG; i++) f[32*i +: 32] = model_regs[i];
        return f;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NREG; i++) model_regs[i] = 32'h0;
        wr_count = 32'h0;
    endtask

    // Response monitors: pop expected values on every handshake, and check that
    // a stalled response stays stable while the address channels stay blocked.
    logic        b_stall_prev = 1'b0;
    logic [1:0]  bresp_prev   = 2'b00;
    logic        r_stall_prev = 1'b0;
    logic [33:0] r_prev       = '0;

    always @(negedge ACLK) begin
        if (!ARESET) begin
            if (b_stall_prev) check("b_hold", {BVALID, BRESP}, {1'b1, bresp_prev});
            if (BVALID) check("aw_w_blocked", {AWREADY, WREADY}, 2'b00);
            if (BVALID && BREADY) begin
                if (bq.size() == 0) fail_now("b_unexpected_response");
                else check("bresp", BRESP, bq.pop_front());
            end
        end
        b_stall_prev <= !ARESET && BVALID && !BREADY;
        bresp_prev   <= BRESP;
    end

    always @(negedge ACLK) begin
        if (!ARESET) begin
            if (r_stall_prev) check("r_hold", {RVALID, RRESP, RDATA}, {1'b1, r_prev});
            if (RVALID) check("ar_blocked", ARREADY, 1'b0);
            if (RVALID && RREADY) begin
                if (rq.size() == 0) fail_now("r_unexpected_response");
                else check("rresp_rdata", {RRESP, RDATA}, rq.pop_front());
            end
        end
        r_stall_prev <= !ARESET && RVALID && !RREADY;
        r_prev       <= {RRESP, RDATA};
    end

    task automatic drive_aw(input logic [AW-1:0] addr, input int dly);
        int cnt;
        repeat (dly) begin @(posedge ACLK); #1; end
        AWADDR  = addr;
        AWVALID = 1'b1;
        cnt = 0;
        do begin @(negedge ACLK); cnt++; end while (!AWREADY && cnt < 100);
        if (!AWREADY) fail_now("aw_accept_timeout");
        @(posedge ACLK); #1;
        AWVALID = 1'b0;
        AWADDR  = AW'($urandom);
        check("awready_low_after_aw", AWREADY, 1'b0);
    endtask

    task automatic drive_w(input logic [31:0] data, input logic [3:0] strb, input int dly);
        int cnt;
        repeat (dly) begin @(posedge ACLK); #1; end
        WDATA  = data;
        WSTRB  = strb;
        WVALID = 1'b1;
        cnt = 0;
        do begin @(negedge ACLK); cnt++; end while (!WREADY && cnt < 100);
        if (!WREADY) fail_now("w_accept_timeout");
        @(posedge ACLK); #1;
        WVALID = 1'b0;
        WDATA  = $urandom;
        check("wready_low_after_w", WREADY, 1'b0);
    endtask

    task automatic do_write(input logic [AW-1:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int b_dly);
        int cnt;
        bq.push_back(model_write(addr, data, strb));
        BREADY = 1'b0;
        fork
            drive_aw(addr, aw_dly);
            drive_w(data, strb, w_dly);
        join
        // Response must appear at the edge where the later half was accepted.
        check("bvalid_at_commit_edge", BVALID, 1'b1);
        repeat (b_dly) begin @(posedge ACLK); #1; end
        BREADY = 1'b1;
        cnt = 0;
        do begin @(negedge ACLK); cnt++; end while (!(BVALID && BREADY) && cnt < 100);
        if (!BVALID) fail_now("b_timeout");
        @(posedge ACLK); #1;
        BREADY = 1'b0;
        check("reg_out", REG_OUT, model_flat());
    endtask

    task automatic do_read(input logic [AW-1:0] addr, input logic [33:0] exp, input int ar_dly,
                           input int r_dly);
        int cnt;
        rq.push_back(exp);
        RREADY = 1'b0;
        repeat (ar_dly) begin @(posedge ACLK); #1; end
        ARADDR  = addr;
        ARVALID = 1'b1;
        cnt = 0;
        do begin @(negedge ACLK); cnt++; end while (!ARREADY && cnt < 100);
        if (!ARREADY) fail_now("ar_accept_timeout");
        @(posedge ACLK); #1;
        ARVALID = 1'b0;
        ARADDR  = AW'($urandom);
        check("rvalid_at_ar_edge", {RVALID, ARREADY}, 2'b10);
        repeat (r_dly) begin @(posedge ACLK); #1; end
        RREADY = 1'b1;
        cnt = 0;
        do begin @(negedge ACLK); cnt++; end while (!(RVALID && RREADY) && cnt < 100);
        if (!RVALID) fail_now("r_timeout");
        @(posedge ACLK); #1;
        RREADY = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no end of test, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [AW-1:0] a, a2;
        logic [33:0]   e;
        ARESET  = 1'b1;
        AWADDR  = '0; AWPROT = 3'b0; AWVALID = 1'b0;
        WDATA   = '0; WSTRB  = 4'h0; WVALID  = 1'b0; BREADY = 1'b0;
        ARADDR  = '0; ARPROT = 3'b0; ARVALID = 1'b0; RREADY = 1'b0;
        model_clear();

        // Reset state and READY release timing.
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        check("reset_ctrl", {AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP}, 9'h0);
        check("reset_rdata", RDATA, 32'h0);
        check("reset_reg_out", REG_OUT, '0);
        @(posedge ACLK); #1;
        ARESET = 1'b0;
        check("ready_low_before_edge", {AWREADY, WREADY, ARREADY}, 3'b000);
        @(posedge ACLK); #1;
        check("ready_high_after_edge", {AWREADY, WREADY, ARREADY}, 3'b111);

        // Sequential writes, then read-back.
        for (int i = 0; i < 4; i++) do_write(AW'(i * 4), 32'(i + 1), 4'hF, 0, 0, 0);
        for (int i = 0; i < 4; i++) do_read(AW'(i * 4), {2'b00, 32'(i + 1)}, 0, 0);

        // AW before W by 3 cycles, then W before AW.
        do_write(5'h04, 32'hA5A5_0001, 4'hF, 0, 3, 1);
        do_write(5'h08, 32'h5A5A_0002, 4'hF, 3, 0, 0);
        do_read(5'h04, {2'b00, 32'hA5A5_0001}, 0, 0);
        do_read(5'h08, {2'b00, 32'h5A5A_0002}, 0, 0);

        // Byte strobes, empty strobe, ignored low address bits.
        do_write(5'h00, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
        do_write(5'h00, 32'h1234_5678, 4'b0101, 0, 0, 0);
        do_read(5'h00, {2'b00, 32'hFF34_FF78}, 0, 0);
        do_write(5'h0C, 32'hDEAD_BEEF, 4'h0, 1, 0, 0);
        do_read(5'h0C, {2'b00, 32'h0000_0004}, 0, 0);
        do_write(5'h07, 32'h0BAD_F00D, 4'hF, 0, 1, 0);
        do_read(5'h05, {2'b00, 32'h0BAD_F00D}, 0, 0);

        // Out-of-range writes and reads.
        do_write(5'h10, 32'hCAFE_F00D, 4'hF, 0, 0, 0);
        do_write(5'h1C, 32'hCAFE_F00D, 4'hF, 0, 0, 0);
        do_read(5'h10, model_read(5'h10), 0, 0);
        do_read(5'h14, {2'b10, 32'h0}, 0, 0);

        // Back-pressure on B and R for 5 cycles.
        do_write(5'h08, 32'h0BAD_CAFE, 4'hF, 0, 0, 5);
        do_read(5'h08, {2'b00, 32'h0BAD_CAFE}, 0, 5);

        // Read and write to the same word at the same edge.
        e = model_read(5'h04);
        fork
            do_write(5'h04, 32'h7777_7777, 4'hF, 0, 0, 0);
            do_read(5'h04, e, 0, 0);
        join
        do_read(5'h04, {2'b00, 32'h7777_7777}, 0, 0);

        // Randomized traffic against the model.
        for (int n = 0; n < 40; n++) begin
            a  = AW'($urandom_range(0, 31));
            a2 = AW'($urandom_range(0, 31));
            if (n % 8 == 7) begin
                e = model_read(a2);
                fork
                    do_write(a, $urandom, 4'($urandom_range(0, 15)), 0, 0, 0);
                    do_read(a2, e, 0, 0);
                join
            end else if ($urandom_range(0, 1) == 1) begin
                do_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                         $urandom_range(0, 3), $urandom_range(0, 2));
            end else begin
                do_read(a, model_read(a), $urandom_range(0, 3), $urandom_range(0, 2));
            end
        end

        // Reset with an address held and no data: everything is dropped.
        AWADDR  = 5'h04;
        AWVALID = 1'b1;
        @(negedge ACLK);
        if (!AWREADY) fail_now("aw_before_reset");
        @(posedge ACLK); #1;
        AWVALID = 1'b0;
        check("aw_held_blocks_awready", AWREADY, 1'b0);
        ARESET = 1'b1;
        @(posedge ACLK); #1;
        ARESET = 1'b0;
        model_clear();
        check("reset_clears_regs", REG_OUT, '0);
        check("reset_drops_pending", {BVALID, RVALID, AWREADY}, 3'b000);
        BREADY = 1'b1;
        repeat (6) begin
            @(posedge ACLK); #1;
            check("no_b_for_dropped_aw", BVALID, 1'b0);
        end
        BREADY = 1'b0;
        check("ready_after_midreset", {AWREADY, WREADY, ARREADY}, 3'b111);

        // Three OKAY writes, then index NUM_REGS.
        do_write(5'h00, 32'h0000_0011, 4'hF, 0, 0, 0);
        do_write(5'h04, 32'h0000_0022, 4'hF, 0, 2, 0);
        do_write(5'h18, 32'h0000_0033, 4'hF, 0, 0, 0);
        do_write(5'h0C, 32'h0000_0044, 4'h3, 2, 0, 0);
        do_write(5'h10, 32'h0000_0055, 4'hF, 0, 0, 0);
`ifdef QSIP_AXIL_WRCOUNT_EN
        do_read(5'h10, {2'b00, 32'd3}, 0, 0);
`else
        do_read(5'h10, {2'b10, 32'd0}, 0, 0);
`endif
        do_read(5'h0C, {2'b00, 32'h0000_0044}, 0, 0);

        repeat (3) @(posedge ACLK);
        #1;
        check("b_queue_drained", 32'(bq.size()), 32'd0);
        check("r_queue_drained", 32'(rq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
